// File: rtl/fpu_hazard_pkg.sv
// fpu_hazard_pkg: shared types and constants for the FPU hazard scheduler.
// Contents: scheduler state encoding, default multi-cycle latency, register address width.
// No ports. Imported by hazard_load_use_det and fpu_hazard_sched.
package fpu_hazard_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MC_RUN = 2'd1,
    MC_WB  = 2'd2
  } state_e;

  localparam int MC_LAT_DEF = 8;
  localparam int REG_ADDR_W = 5;

endpackage

// File: rtl/fpu_hazard_sched_load_use_det.sv
// hazard_load_use_det: combinational load-use hazard match on the integer and float files.
// Latency: zero (pure combinational). No backpressure; the result is consumed by the scheduler.
// Ports: decode source operands with file flags, EX destination with load/write flags -> hit.
module hazard_load_use_det
  import fpu_hazard_pkg::*;
(
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_f,
  input  logic                  id_rs2_f,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic                  ex_reg_write_f,
  output logic                  hit
);

  logic rs1_eq;
  logic rs2_eq;
  logic int_match;
  logic flt_match;

  assign rs1_eq = (id_rs1 == ex_rd);
  assign rs2_eq = (id_rs2 == ex_rd);

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign int_match = ex_reg_write && (ex_rd != '0) &&
                     ((!id_rs1_f && rs1_eq) || (id_uses_rs2 && !id_rs2_f && rs2_eq));

  // f0 is an ordinary register: no zero exemption on the float side.
  assign flt_match = ex_reg_write_f &&
                     ((id_rs1_f && rs1_eq) || (id_uses_rs2 && id_rs2_f && rs2_eq));

  assign hit = id_valid && ex_mem_read && (int_match || flt_match);

endmodule

// File: rtl/fpu_hazard_sched.sv
// fpu_hazard_sched: load-use stall/bubble generation and multi-cycle FPU op sequencing.
// Latency: stall/bubble/start are combinational from the current cycle's inputs; busy/wb follow the state register.
// Backpressure: load-use stalls IF/ID for one cycle; a multi-cycle op freezes IF/ID/EX until its writeback cycle.
// Ports: clk, rst (sync, active high); decode/EX hazard inputs, branch_taken, fpu_done;
//        stall_fetch, stall_decode, stall_ex, bubble_ex, mc_start, mc_busy, mc_wb_valid.
// Build option: FPU_DONE_HANDSHAKE_EN -- when defined, MC_RUN ends on fpu_done instead of the MC_LAT countdown.
module fpu_hazard_sched
  import fpu_hazard_pkg::*;
#(
  parameter int MC_LAT = MC_LAT_DEF,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_f,
  input  logic                  id_rs2_f,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic                  ex_reg_write_f,
  input  logic                  ex_mc_op,
  input  logic                  branch_taken,
  input  logic                  fpu_done,
  output logic                  stall_fetch,
  output logic                  stall_decode,
  output logic                  stall_ex,
  output logic                  bubble_ex,
  output logic                  mc_start,
  output logic                  mc_busy,
  output logic                  mc_wb_valid
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu_hit;

`ifndef FPU_DONE_HANDSHAKE_EN
  logic unused_fpu_done;
  assign unused_fpu_done = fpu_done;
`endif

  hazard_load_use_det u_lu_det (
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rs1_f       (id_rs1_f),
    .id_rs2_f       (id_rs2_f),
    .id_uses_rs2    (id_uses_rs2),
    .ex_rd          (ex_rd),
    .ex_mem_read    (ex_mem_read),
    .ex_reg_write   (ex_reg_write),
    .ex_reg_write_f (ex_reg_write_f),
    .hit            (lu_hit)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_fetch  = 1'b0;
    stall_decode = 1'b0;
    stall_ex     = 1'b0;
    bubble_ex    = 1'b0;
    mc_start     = 1'b0;
    mc_busy      = 1'b0;
    mc_wb_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        if (branch_taken) begin
          // The instruction in ID is wrong-path: squash rather than stall it.
          bubble_ex = 1'b1;
        end else begin
          stall_fetch  = lu_hit;
          stall_decode = lu_hit;
          bubble_ex    = lu_hit;
          if (ex_mc_op) begin
            mc_start = 1'b1;
            cnt_d    = CNT_W'(MC_LAT - 1);
            state_d  = MC_RUN;
          end
        end
      end

      MC_RUN: begin
        // Load-use is masked here; the whole front end is frozen anyway.
        mc_busy      = 1'b1;
        stall_fetch  = 1'b1;
        stall_decode = 1'b1;
        stall_ex     = 1'b1;
`ifdef FPU_DONE_HANDSHAKE_EN
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (fpu_done) state_d = MC_WB;
`else
        if (cnt_q == '0) state_d = MC_WB;
        else             cnt_d   = cnt_q - 1'b1;
`endif
      end

      MC_WB: begin
        // Stalls drop so the op moves to MEM on this edge. Load-use is
        // evaluated against the held op, which is never a load.
        mc_busy      = 1'b1;
        mc_wb_valid  = 1'b1;
        stall_fetch  = lu_hit;
        stall_decode = lu_hit;
        bubble_ex    = lu_hit;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Outputs are quiet during reset even though several are combinational.
    if (rst) begin
      stall_fetch  = 1'b0;
      stall_decode = 1'b0;
      stall_ex     = 1'b0;
      bubble_ex    = 1'b0;
      mc_start     = 1'b0;
      mc_busy      = 1'b0;
      mc_wb_valid  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
